// File: rtl/wb_split_pkg.sv
// wb_split_pkg: shared types and constants for the Wishbone splitter.
package wb_split_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam int DFLT_REGION_LOG2 = 16;
  localparam int DFLT_TIMEOUT = 255;
  localparam logic [31:0] DFLT_DATA_WORD = 32'hDEAD_BEEF;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_addr_decode.sv
// wb_addr_decode: N-way region compare with lowest-index priority.
module wb_addr_decode import wb_split_pkg::*; #(
  parameter int N_SLAVES = 8,
  parameter int ADDR_W = 32,
  parameter int REGION_LOG2 = DFLT_REGION_LOG2,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter int IDX_W = idx_width(N_SLAVES)
) (
  input  logic [ADDR_W-REGION_LOG2-1:0] adr_hi,
  output logic [N_SLAVES-1:0]           hit,
  output logic                          hit_valid,
  output logic [IDX_W-1:0]              idx
);
  logic [N_SLAVES-1:0] match;
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_cmp
    assign match[i] = adr_hi == SLAVE_BASE[i*ADDR_W+REGION_LOG2 +: ADDR_W-REGION_LOG2];
  end
  // isolate the lowest set bit so overlapping regions stay one-hot
  assign hit = match & (~match + N_SLAVES'(1));
  assign hit_valid = |match;
  always_comb begin
    idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--)
      if (match[i]) idx = IDX_W'(i);
  end
endmodule

// File: rtl/wb_splitter_n.sv
// wb_splitter_n: Wishbone 1-to-N splitter with timeout watchdog and sticky error capture.
module wb_splitter_n import wb_split_pkg::*; #(
  parameter int N_SLAVES = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter int REGION_LOG2 = DFLT_REGION_LOG2,
  parameter int TIMEOUT = DFLT_TIMEOUT,
  parameter logic [DATA_W-1:0] DFLT_DATA = DFLT_DATA_WORD
) (
  input  logic                       wb_clk,
  input  logic                       wb_rst_n,
  input  logic [ADDR_W-1:0]          wb_adr,
  input  logic                       wb_we,
  input  logic                       wb_stb,
  input  logic                       wb_cyc,
  output logic [DATA_W-1:0]          wb_dat_o,
  output logic                       wb_ack,
  output logic                       wb_err,
  output logic [N_SLAVES-1:0]        s_stb,
  output logic [N_SLAVES-1:0]        s_cyc,
  input  logic [N_SLAVES*DATA_W-1:0] s_dat,
  input  logic [N_SLAVES-1:0]        s_ack,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic [1:0]                 err_code,
  output logic [ADDR_W-1:0]          err_addr
);
  localparam int IDX_W = idx_width(N_SLAVES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  state_t state;
  logic [IDX_W-1:0] idx_q, dec_idx, sel_idx;
  logic [N_SLAVES-1:0] dec_oh, sel_oh;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-1:0] adr_q;
  logic dec_hit, req, active, sel_ack, tmo, go_err;
  wb_addr_decode #(
    .N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .REGION_LOG2(REGION_LOG2),
    .SLAVE_BASE(SLAVE_BASE), .IDX_W(IDX_W)
  ) u_dec (
    .adr_hi(wb_adr[ADDR_W-1:REGION_LOG2]),
    .hit(dec_oh),
    .hit_valid(dec_hit),
    .idx(dec_idx)
  );
  assign req = wb_cyc & wb_stb;
  // IDLE follows the live decode; WAIT holds the selection latched at request time
  assign sel_idx = state == IDLE ? dec_idx : idx_q;
  assign sel_oh = state == IDLE ? dec_oh : N_SLAVES'(1) << idx_q;
  assign active = wb_rst_n & ((state == IDLE & req & dec_hit) | (state == WAIT & wb_cyc));
  assign sel_ack = s_ack[sel_idx];
  assign tmo = cnt >= CNT_W'(TIMEOUT - 1);
  assign go_err = (state == IDLE & req & ~dec_hit) | (state == WAIT & wb_cyc & ~sel_ack & tmo);
  assign s_cyc = active ? sel_oh : '0;
  assign s_stb = (active & wb_stb) ? sel_oh : '0;
  assign wb_ack = active & sel_ack;
  assign wb_err = state == ERR;
  assign wb_dat_o = active ? s_dat[sel_idx*DATA_W +: DATA_W] : DFLT_DATA;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state <= IDLE;
      idx_q <= '0;
      adr_q <= '0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (req) begin
        idx_q <= dec_idx;
        adr_q <= wb_adr;
        cnt <= '0;
        state <= !dec_hit ? ERR : sel_ack ? IDLE : WAIT;
      end
    end else if (state == WAIT) begin
      cnt <= cnt == CNT_W'(TIMEOUT) ? cnt : cnt + 1'b1;
      state <= (!wb_cyc || sel_ack) ? IDLE : tmo ? ERR : WAIT;
    end else begin
      state <= IDLE;
    end
  end
  // a fresh error wins over a simultaneous clear; otherwise the first error is kept
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      err_valid <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end else if (go_err && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_code <= state == IDLE ? ERR_UNMAPPED : ERR_TIMEOUT;
      err_addr <= state == IDLE ? wb_adr : adr_q;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_code <= ERR_NONE;
      err_addr <= '0;
    end
  end
endmodule
